// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if;
   // fetch requester
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        f_err;
   // load/store requester
   logic        d_req;
   logic        d_wren;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   // memory side
   logic [31:0] m_addr;
   logic        m_wren;
   logic [2:0]  m_funct3;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   // status
   logic        busy;

   // arbiter view
   modport slave (
      input  f_req, f_addr, d_req, d_wren, d_funct3, d_addr, d_wdata, m_rdata,
      output f_gnt, f_rvalid, f_rdata, f_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output m_addr, m_wren, m_funct3, m_wdata, busy
   );

   // requester/memory view
   modport master (
      output f_req, f_addr, d_req, d_wren, d_funct3, d_addr, d_wdata, m_rdata,
      input  f_gnt, f_rvalid, f_rdata, f_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  m_addr, m_wren, m_funct3, m_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter #(
   parameter int MEM_LATENCY     = 1,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.slave  bus
);
   localparam int              SW         = (MAX_DATA_STREAK > 1) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DATA_STREAK);
   localparam logic [2:0]      LAT_LAST   = 3'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next_state;

   logic         r_sel_data;   // 1: data requester owns the access in flight
   logic [31:0]  r_addr;
   logic         r_wren;
   logic [2:0]   r_funct3;
   logic [31:0]  r_wdata;
   logic         r_misal;
   logic [2:0]   r_lat_cnt;
   logic [31:0]  r_rdata;
   logic [SW-1:0] r_streak;

   logic         w_force_fetch;
   logic         w_gnt_f;
   logic         w_gnt_d;
   logic         w_last;
   logic         w_d_misal;
   logic         w_f_misal;
   logic         w_access;
   logic         w_resp;

   assign w_access = (r_state == S_ACCESS);
   assign w_resp   = (r_state == S_RESP);
   assign w_last   = w_access && (r_lat_cnt == LAT_LAST);

   // Fetch gets one turn once data has starved it for MAX_DATA_STREAK grants.
   assign w_force_fetch = (MAX_DATA_STREAK != 0) && bus.f_req && (r_streak == STREAK_MAX);
   assign w_gnt_d = (r_state == S_IDLE) && bus.d_req && !w_force_fetch;
   assign w_gnt_f = (r_state == S_IDLE) && bus.f_req && (!bus.d_req || w_force_fetch);

   assign w_f_misal = (bus.f_addr[1:0] != 2'b00);

   // Alignment by access size; funct3[1:0] covers the signed and unsigned variants alike.
   always_comb begin
      w_d_misal = 1'b0;
      case (bus.d_funct3[1:0])
         2'b00:   w_d_misal = 1'b0;
         2'b01:   w_d_misal = bus.d_addr[0];
         default: w_d_misal = (bus.d_addr[1:0] != 2'b00);
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next state: grant starts an access, last latency cycle hands over to the response.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_gnt_f || w_gnt_d) w_next_state = S_ACCESS;
         S_ACCESS: if (w_last) w_next_state = S_RESP;
         S_RESP:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Capture the winner's payload at the grant edge; later payload changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel_data <= 1'b0;
         r_addr     <= 32'd0;
         r_wren     <= 1'b0;
         r_funct3   <= 3'd0;
         r_wdata    <= 32'd0;
         r_misal    <= 1'b0;
      end else if (w_gnt_d) begin
         r_sel_data <= 1'b1;
         r_addr     <= bus.d_addr;
         r_wren     <= bus.d_wren;
         r_funct3   <= bus.d_funct3;
         r_wdata    <= bus.d_wdata;
         r_misal    <= w_d_misal;
      end else if (w_gnt_f) begin
         r_sel_data <= 1'b0;
         r_addr     <= bus.f_addr;
         r_wren     <= 1'b0;
         r_funct3   <= 3'b010;
         r_wdata    <= 32'd0;
         r_misal    <= w_f_misal;
      end
   end

   // Latency counter runs 0..MEM_LATENCY-1 inside ACCESS, idle at 0 elsewhere.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_lat_cnt <= 3'd0;
      else if (w_access && !w_last) r_lat_cnt <= r_lat_cnt + 3'd1;
      else                         r_lat_cnt <= 3'd0;
   end

   // Response data sampled on the last ACCESS cycle; stores and misaligned accesses return 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_rdata <= 32'd0;
      else if (w_last) r_rdata <= (r_misal || r_wren) ? 32'd0 : bus.m_rdata;
   end

   // Data-grant streak while fetch waits; cleared whenever fetch is idle or served.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_streak <= '0;
      else if (!bus.f_req || w_gnt_f)        r_streak <= '0;
      else if (w_gnt_d && r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
   end

   assign bus.f_gnt    = w_gnt_f;
   assign bus.d_gnt    = w_gnt_d;

   assign bus.f_rvalid = w_resp && !r_sel_data;
   assign bus.f_rdata  = bus.f_rvalid ? r_rdata : 32'd0;
   assign bus.f_err    = bus.f_rvalid && r_misal;

   assign bus.d_rvalid = w_resp && r_sel_data;
   assign bus.d_rdata  = bus.d_rvalid ? r_rdata : 32'd0;
   assign bus.d_err    = bus.d_rvalid && r_misal;

   assign bus.m_addr   = w_access ? r_addr   : 32'd0;
   assign bus.m_funct3 = w_access ? r_funct3 : 3'd0;
   assign bus.m_wdata  = w_access ? r_wdata  : 32'd0;
   assign bus.m_wren   = w_access && r_wren && !r_misal && (r_lat_cnt == 3'd0);

   assign bus.busy     = (r_state != S_IDLE);
endmodule
